// File: rtl/dmem_responder_if.sv
// Data-memory bus between a core's load/store unit and its memory.
// The requester drives the master side and the memory responds on the slave side.
interface dmem_responder_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic [31:0] rdata;
  logic        err;
  logic        busy;

  modport master (
    output req, we, addr, wdata,
    input  ready, rdata, err, busy
  );

  modport slave (
    input  req, we, addr, wdata,
    output ready, rdata, err, busy
  );
endinterface

// File: rtl/dmem_responder.sv
// Word RAM behind the data-memory bus with fixed wait states and fault reporting.
// Define DMEM_MMIO_EN to map an output register at byte address 0xFFFF_FFFC.
module dmem_responder #(
  parameter int          DEPTH       = 64,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  dmem_responder_if.slave   bus
`ifdef DMEM_MMIO_EN
  ,
  output logic [31:0]       mmio_out
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_INIT =
    CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t         state_q;
  logic [CW-1:0]  cnt_q;
  logic [31:0]    addr_q;
  logic [31:0]    wdata_q;
  logic           we_q;
  logic           ready_q;
  logic           err_q;
  logic [31:0]    rdata_q;
  logic           busy_q;

  logic [31:0]    mem [DEPTH];

  logic [31:0]    cur_addr;
  logic [31:0]    cur_wdata;
  logic           cur_we;
  logic [31:0]    offset;
  logic [29:0]    index;
  logic [AW-1:0]  idx;
  logic           mmio_hit;
  logic           fault;
  logic           go_resp;
  logic           ram_wr;
  logic [31:0]    rd_word;

`ifdef DMEM_MMIO_EN
  localparam logic [31:0] MMIO_ADDR = 32'hFFFF_FFFC;
  logic [31:0]    mmio_q;
  assign mmio_out = mmio_q;
`endif

  // Decode the access that completes at the next edge; with zero wait
  // states that is the request on the bus, otherwise the latched one.
  always_comb begin
    cur_addr  = bus.addr;
    cur_wdata = bus.wdata;
    cur_we    = bus.we;
    if (state_q != S_IDLE) begin
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
      cur_we    = we_q;
    end
    offset   = cur_addr - BASE_ADDR;
    index    = offset[31:2];
    idx      = offset[AW+1:2];
    mmio_hit = 1'b0;
`ifdef DMEM_MMIO_EN
    mmio_hit = (cur_addr == MMIO_ADDR);
`endif
    fault    = !mmio_hit &&
               ((offset[1:0] != 2'b00) ||
                ({2'b00, index} >= 32'(DEPTH)));
    go_resp  = ((state_q == S_IDLE) && bus.req &&
                (WAIT_CYCLES == 0)) ||
               ((state_q == S_WAIT) && (cnt_q == '0));
    ram_wr   = go_resp && cur_we && !fault && !mmio_hit;
    rd_word  = mem[idx];
`ifdef DMEM_MMIO_EN
    if (mmio_hit) rd_word = mmio_q;
`endif
  end

  // RAM array: no reset, written on the edge that enters RESP.
  always_ff @(posedge clk) begin
    if (ram_wr && !reset) mem[idx] <= cur_wdata;
  end

  // Request FSM with registered completion outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
`ifdef DMEM_MMIO_EN
      mmio_q  <= '0;
`endif
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      unique case (state_q)
        S_IDLE: begin
          if (bus.req) begin
            addr_q  <= bus.addr;
            wdata_q <= bus.wdata;
            we_q    <= bus.we;
            busy_q  <= 1'b1;
            cnt_q   <= CNT_INIT;
            state_q <= (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_q == '0) state_q <= S_RESP;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        S_RESP: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
      if (go_resp) begin
        ready_q <= 1'b1;
        err_q   <= fault;
        rdata_q <= (!cur_we && !fault) ? rd_word : '0;
`ifdef DMEM_MMIO_EN
        if (mmio_hit && cur_we) mmio_q <= cur_wdata;
`endif
      end
    end
  end

  assign bus.ready = ready_q;
  assign bus.err   = err_q;
  assign bus.rdata = rdata_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (2 and 0 wait states)
// checked against a reference word model through expected-result queues.
module tb_dmem_responder;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  exp_t q2[$];
  exp_t q0[$];
  exp_t e2;
  exp_t e0;

  logic [31:0] m2 [64];
  logic [31:0] m0 [64];
  logic [31:0] mm_model = 32'h0;

  dmem_responder_if a();
  dmem_responder_if z();

`ifdef DMEM_MMIO_EN
  logic [31:0] mmio2;
  logic [31:0] mmio0;
`endif

  dmem_responder #(
    .DEPTH(64), .WAIT_CYCLES(2), .BASE_ADDR(32'h0000_0000)
  ) u2 (
    .clk(clk), .reset(reset), .bus(a)
`ifdef DMEM_MMIO_EN
    , .mmio_out(mmio2)
`endif
  );

  dmem_responder #(
    .DEPTH(64), .WAIT_CYCLES(0), .BASE_ADDR(32'h0000_1000)
  ) u0 (
    .clk(clk), .reset(reset), .bus(z)
`ifdef DMEM_MMIO_EN
    , .mmio_out(mmio0)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #400000;
    $display("FAIL global_timeout reached");
    $fatal(1);
  end

  function automatic exp_t model(input bit d0, input logic we,
                                 input logic [31:0] addr,
                                 input logic [31:0] wdata);
    exp_t r;
    logic [31:0] base;
    logic [31:0] off;
    bit fault;
    bit mm;
    int idx;
    base = d0 ? 32'h0000_1000 : 32'h0;
    off = addr - base;
    mm = 1'b0;
`ifdef DMEM_MMIO_EN
    mm = (addr == 32'hFFFF_FFFC);
`endif
    fault = !mm && ((addr[1:0] != 2'b00) || (off[31:2] >= 30'd64));
    r.err = fault;
    r.rdata = 32'h0;
    if (mm) begin
      if (we) mm_model = wdata;
      else    r.rdata = mm_model;
    end else if (!fault) begin
      idx = int'(off[31:2]);
      if (d0) begin
        if (we) m0[idx] = wdata;
        else    r.rdata = m0[idx];
      end else begin
        if (we) m2[idx] = wdata;
        else    r.rdata = m2[idx];
      end
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (!reset && a.ready === 1'b1) begin
      checks++;
      if (q2.size() == 0) begin
        errors++;
        $display("FAIL d2_unexpected_ready t=%0t err=%b rdata=%h",
                 $time, a.err, a.rdata);
      end else begin
        e2 = q2.pop_front();
        if ({a.err, a.rdata} !== {e2.err, e2.rdata}) begin
          errors++;
          $display("FAIL d2_resp got err=%b rdata=%h want err=%b rdata=%h",
                   a.err, a.rdata, e2.err, e2.rdata);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && z.ready === 1'b1) begin
      checks++;
      if (q0.size() == 0) begin
        errors++;
        $display("FAIL d0_unexpected_ready t=%0t err=%b rdata=%h",
                 $time, z.err, z.rdata);
      end else begin
        e0 = q0.pop_front();
        if ({z.err, z.rdata} !== {e0.err, e0.rdata}) begin
          errors++;
          $display("FAIL d0_resp got err=%b rdata=%h want err=%b rdata=%h",
                   z.err, z.rdata, e0.err, e0.rdata);
        end
      end
    end
  end

  task automatic issue2(input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, output int lat);
    int a0;
    int t;
    @(negedge clk);
    a.we = we;
    a.addr = addr;
    a.wdata = wdata;
    a.req = 1'b1;
    q2.push_back(model(1'b0, we, addr, wdata));
    a0 = cyc;
    @(posedge clk);
    #1;
    a.req = 1'b0;
    a.we = ~we;
    a.addr = 32'hFFFF_FFF1;
    a.wdata = 32'h5A5A_5A5A;
    lat = -1;
    t = 0;
    while (t < 20) begin
      @(negedge clk);
      if (a.ready === 1'b1) begin
        lat = cyc - a0;
        break;
      end
      t++;
    end
    if (lat < 0) begin
      checks++;
      errors++;
      $display("FAIL d2_ready_timeout addr=%h got none want ready", addr);
    end
  endtask

  task automatic test_reset;
    a.req = 1'b0; a.we = 1'b0; a.addr = '0; a.wdata = '0;
    z.req = 1'b0; z.we = 1'b0; z.addr = '0; z.wdata = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({a.ready, a.err, a.busy} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags got %b want 000", {a.ready, a.err, a.busy});
    end
    checks++;
    if (a.rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_rdata got %h want 0", a.rdata);
    end
    checks++;
    if ({z.ready, z.err, z.busy} !== 3'b000 || z.rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_d0 got %b %h want 000 0",
               {z.ready, z.err, z.busy}, z.rdata);
    end
`ifdef DMEM_MMIO_EN
    checks++;
    if (mmio2 !== 32'h0) begin
      errors++;
      $display("FAIL reset_mmio got %h want 0", mmio2);
    end
`endif
    reset = 1'b0;
  endtask

  task automatic test_store_load;
    int lat;
    issue2(1'b1, 32'h10, 32'hDEAD_BEEF, lat);
    checks++;
    if (lat !== 3) begin
      errors++;
      $display("FAIL store_latency got %0d want 3", lat);
    end
    checks++;
    if (a.busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_at_ready got %b want 1", a.busy);
    end
    @(negedge clk);
    checks++;
    if ({a.busy, a.ready} !== 2'b00) begin
      errors++;
      $display("FAIL after_resp busy/ready got %b want 00", {a.busy, a.ready});
    end
    issue2(1'b0, 32'h10, 32'h0, lat);
    checks++;
    if (lat !== 3) begin
      errors++;
      $display("FAIL load_latency got %0d want 3", lat);
    end
  endtask

  task automatic test_fault;
    int lat;
    issue2(1'b0, 32'h13, 32'h0, lat);
    issue2(1'b1, 32'h12, 32'h1234_5678, lat);
    issue2(1'b0, 32'h10, 32'h0, lat);
    issue2(1'b1, 32'h100, 32'hBAD0_BAD0, lat);
    issue2(1'b1, 32'hFC, 32'h6363_6363, lat);
    issue2(1'b0, 32'hFC, 32'h0, lat);
    issue2(1'b1, 32'h0, 32'h0000_0007, lat);
    issue2(1'b0, 32'h0, 32'h0, lat);
    issue2(1'b0, 32'h10, 32'h0, lat);
  endtask

  task automatic test_reset_abort;
    int lat;
    int pulses;
    issue2(1'b1, 32'h20, 32'h0000_0001, lat);
    @(negedge clk);
    a.we = 1'b1;
    a.addr = 32'h20;
    a.wdata = 32'h0000_0055;
    a.req = 1'b1;
    @(posedge clk);
    #1;
    a.req = 1'b0;
    @(negedge clk);
    checks++;
    if (a.busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_busy_in_wait got %b want 1", a.busy);
    end
    #1;
    reset = 1'b1;
    #2;
    checks++;
    if ({a.busy, a.ready} !== 2'b00) begin
      errors++;
      $display("FAIL abort_async got %b want 00", {a.busy, a.ready});
    end
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    repeat (5) begin
      @(negedge clk);
      if (a.ready === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL abort_no_ready got %0d pulses want 0", pulses);
    end
    issue2(1'b0, 32'h20, 32'h0, lat);
  endtask

  task automatic test_mmio;
    int lat;
    issue2(1'b1, 32'hFFFF_FFFC, 32'h0000_00A5, lat);
`ifdef DMEM_MMIO_EN
    checks++;
    if (mmio2 !== 32'h0000_00A5) begin
      errors++;
      $display("FAIL mmio_out got %h want 000000a5", mmio2);
    end
`endif
    issue2(1'b0, 32'hFFFF_FFFC, 32'h0, lat);
  endtask

  task automatic test_back_to_back;
    logic        we_t [8];
    logic [31:0] ad_t [8];
    logic [31:0] wd_t [8];
    int last;
    int t;
    we_t = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    ad_t = '{32'h1000, 32'h1004, 32'h1000, 32'h1004,
             32'h0FFC, 32'h1100, 32'h10FC, 32'h10FC};
    wd_t = '{32'h1111_1111, 32'h2222_2222, 32'h0, 32'h0,
             32'h0, 32'h9999_9999, 32'hCAFE_F00D, 32'h0};
    last = 0;
    @(negedge clk);
    z.we = we_t[0];
    z.addr = ad_t[0];
    z.wdata = wd_t[0];
    z.req = 1'b1;
    q0.push_back(model(1'b1, we_t[0], ad_t[0], wd_t[0]));
    for (int i = 0; i < 8; i++) begin
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (z.ready !== 1'b1 && t < 6);
      if (z.ready !== 1'b1) begin
        checks++;
        errors++;
        $display("FAIL b2b_timeout txn=%0d got none want ready", i);
        break;
      end
      if (i > 0) begin
        checks++;
        if (cyc - last !== 2) begin
          errors++;
          $display("FAIL b2b_spacing txn=%0d got %0d want 2", i, cyc - last);
        end
      end
      last = cyc;
      if (i < 7) begin
        z.we = we_t[i+1];
        z.addr = ad_t[i+1];
        z.wdata = wd_t[i+1];
        q0.push_back(model(1'b1, we_t[i+1], ad_t[i+1], wd_t[i+1]));
      end else begin
        z.req = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset;
    test_store_load;
    test_fault;
    test_reset_abort;
    test_mmio;
    test_back_to_back;
    repeat (6) @(negedge clk);
    checks++;
    if (q2.size() !== 0 || q0.size() !== 0) begin
      errors++;
      $display("FAIL pending_responses got %0d/%0d want 0/0",
               q2.size(), q0.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder on the far end of the processor's data-memory bus. It accepts word load/store requests (address, store data, write strobe) and returns load data and a completion pulse.
- Models a word-addressed RAM with a fixed number of wait states, so a multi-cycle or stalling core can be exercised against realistic memory latency.
- Sits between the datapath's memory-side outputs (ALU result as address, register read data as store data) and its load-data input.

Parameters:
- DEPTH, 64: number of 32-bit words; legal word index 0..DEPTH-1.
- WAIT_CYCLES, 2: wait states between acceptance and response; 0 allowed.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; must be word-aligned.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  1  request strobe; held high by the requester until ready.
- we  in  1  1 = store, 0 = load; sampled with req.
- addr  in  32  byte address; sampled with req.
- wdata  in  32  store data; sampled with req.
- ready  out  1  one-cycle completion pulse.
- rdata  out  32  load data; valid only while ready=1 on a load.
- err  out  1  asserted with ready when the access faulted.
- busy  out  1  high from acceptance until ready, inclusive.
- mmio_out  out  32  output register; present only with DMEM_MMIO_EN.

Behaviour:
- Reset: asynchronous, active-high.
  - Outputs: ready=0, err=0, rdata=0, busy=0, mmio_out=0.
  - Internal: state=IDLE, wait counter=0.
  - RAM contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - On req=1, latch addr/we/wdata and set busy=1 on the next cycle.
  - Go to WAIT with counter=WAIT_CYCLES-1, or straight to RESP if WAIT_CYCLES=0.
- WAIT:
  - Decrement the counter each cycle.
  - Go to RESP when counter=0 at the edge.
  - req and all inputs are ignored here; the latched request completes even if req drops.
- RESP:
  - ready=1 for exactly one cycle, then return to IDLE. ready, rdata and err are registered.
  - A new req is not accepted in the RESP cycle. Minimum request spacing is WAIT_CYCLES+2 cycles.
- Latency: req sampled high in IDLE at cycle A gives ready=1 in cycle A+1+WAIT_CYCLES.
- Address decode:
  - offset = latched addr - BASE_ADDR (32-bit wrap-around subtraction).
  - index = offset[31:2].
- Fault conditions (err=1):
  - misaligned: addr[1:0] != 0;
  - out of range: index >= DEPTH, including wrap below BASE_ADDR.
  - On a fault: no RAM write, rdata=0, ready still pulses.
- Store:
  - The RAM word is written at the edge that enters RESP.
  - In the RESP cycle rdata=0 and err=0 for a legal store.
- Load:
  - rdata is the RAM word as of the edge entering RESP.
  - A load issued after a store to the same word returns the new value.
- Reset during WAIT or RESP: abort to IDLE with no RAM write and no ready pulse.
- busy falls in the cycle after RESP.

Optional Feature:
- Macro: DMEM_MMIO_EN.
- When defined:
  - Byte address 32'hFFFF_FFFC is an MMIO register driving mmio_out.
  - A store there updates mmio_out at the edge entering RESP. A load there returns mmio_out.
  - Neither access touches the RAM, and err=0.
- When undefined:
  - mmio_out is absent.
  - 32'hFFFF_FFFC follows the normal decode, so it is out of range for practical DEPTH and returns err=1.

Test Plan:
- WAIT_CYCLES=2, BASE_ADDR=0: store addr=0x10, wdata=0xDEADBEEF with req at cycle 5.
  - ready=1 in cycle 8, err=0.
  - A following load from 0x10 returns rdata=0xDEADBEEF with ready 3 cycles after its acceptance.
- Load addr=0x13 → ready pulse with err=1, rdata=0. A later load from 0x10 still returns the prior value, showing no corruption.
- DEPTH=64: store to addr=0x100 (index 64) → err=1. Load from 0xFC (index 63) → err=0.
- Reset asserted during WAIT of a store to 0x20 (old value 0x1) → no ready pulse. A load from 0x20 after reset returns 0x1.
- WAIT_CYCLES=0: req held high continuously → ready pulses every 2 cycles; each transaction completes in order.
- With DMEM_MMIO_EN: store 0x0000_00A5 to 0xFFFF_FFFC → mmio_out=0xA5 in the RESP cycle, err=0. A load there returns 0xA5. Without the macro the same store returns err=1.
